sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter num_words, default 4096, SHALL be the number of WORD_SIZE-bit words behind the controller.
REQ-002 Parameter l2_num_words, default 12, SHALL be log2(num_words) and the SRAM address width.
REQ-003 i_clk  input  1  SHALL be the single clock; all logic triggers on the rising edge.
REQ-004 i_rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 i_if_req / o_if_ready / o_if_valid / o_if_err  in/out/out/out  1 each  SHALL form the instruction-fetch handshake.
REQ-006 i_if_addr  input  32  SHALL be the fetch byte address; o_if_data  output  WORD_SIZE  SHALL be the fetch result.
REQ-007 i_ls_req / i_ls_we / o_ls_ready / o_ls_valid / o_ls_err  in/in/out/out/out  1 each  SHALL form the load/store handshake.
REQ-008 i_ls_addr  input  32  byte address; i_ls_wdata  input  WORD_SIZE  store data; i_ls_be  input  4  byte enables; o_ls_rdata  output  WORD_SIZE  load data.
REQ-009 o_sram_re_A, o_sram_addr_A[l2_num_words], i_sram_data_A[WORD_SIZE] SHALL drive SRAM read port A, dedicated to fetch.
REQ-010 o_sram_re_B, o_sram_addr_B[l2_num_words], i_sram_data_B[WORD_SIZE] SHALL drive SRAM read port B, dedicated to loads and read-modify-write.
REQ-011 o_sram_we, o_sram_waddr[l2_num_words], o_sram_wdata[WORD_SIZE] SHALL drive the SRAM write port.

Function
REQ-012 Word address SHALL be addr[l2_num_words+1:2]; a request SHALL be in error when addr[1:0] != 0 or addr >= 4*num_words.
REQ-013 A request SHALL be accepted in a cycle where req && ready; erroring requests SHALL produce no SRAM access.
REQ-014 A fetch accepted in cycle N SHALL assert o_if_valid with o_if_data = SRAM word (or o_if_err=1, data 0) in cycle N+1 only.
REQ-015 o_if_ready SHALL be 1 except in a cycle where o_sram_we=1 and the fetch word address equals o_sram_waddr.
REQ-016 FSM states SHALL be IDLE and RMW; o_ls_ready SHALL equal (state == IDLE).
REQ-017 A load accepted in cycle N SHALL issue a port-B read in N and assert o_ls_valid with o_ls_rdata in N+1; back-to-back loads SHALL sustain one per cycle.
REQ-018 A store with i_ls_be=4'b1111 SHALL write in the accept cycle N, stay in IDLE, and assert o_ls_valid in N+1.
REQ-019 A store with i_ls_be=4'b0000 SHALL perform no SRAM access and assert o_ls_valid in N+1.
REQ-020 Any other store SHALL latch address/data/be, issue a port-B read in N, and go IDLE->RMW.
REQ-021 In RMW (cycle N+1), the controller SHALL write the merge (byte i from i_ls_wdata where be[i]=1, else from i_sram_data_B), return to IDLE, and assert o_ls_valid in N+2.
REQ-022 o_ls_valid SHALL be a one-cycle pulse per accepted request; o_ls_rdata SHALL be 0 for stores and errors.
REQ-023 Simultaneous fetch and load/store SHALL both proceed in the same cycle; a port-B read issued in the cycle after a write to the same word SHALL return the new data.

Reset
REQ-024 On i_rst, state SHALL become IDLE and all valid, err, re and we outputs SHALL be 0, with o_if_data and o_ls_rdata reset to 0.
REQ-025 Reset asserted during RMW SHALL abandon the store with no SRAM write and no o_ls_valid.

Structure
REQ-026 A shared package sram_ctrl_pkg SHALL hold the FSM state enum and byte-lane width constants; WORD_SIZE SHALL come from defaults.sv.
REQ-027 The byte merge SHALL be one combinational sub-module, be_merge.

Verification
REQ-028 Bench SHALL cover fetch of 0x10, where SRAM word 4 = 0xDEADBEEF -> o_if_valid next cycle with data 0xDEADBEEF, o_if_err=0.
REQ-029 Bench SHALL cover store 0x11223344 to 0x20 with be=1111, then load of 0x20 -> o_ls_valid at N+1 and N+3 with rdata 0x11223344.
REQ-030 Bench SHALL cover word 8 = 0xAABBCCDD and store 0x00000055 with be=0001 to 0x20 -> o_ls_ready=0 at N+1, SRAM word 8 = 0xAABBCC55, o_ls_valid at N+2.
REQ-031 Bench SHALL cover a load of 0x22 and a load of 0x4000 (num_words=4096) -> o_ls_err=1, o_ls_rdata=0, o_sram_re_B never asserted.
REQ-032 Bench SHALL cover a fetch of 0x20 in the RMW write cycle for word 8 -> o_if_ready=0 that cycle, fetch accepted next cycle returns the merged word.
REQ-033 Bench SHALL cover i_rst pulsed during RMW -> o_sram_we stays 0, no o_ls_valid, o_ls_ready=1 after release.

Source files
------------

// File: rtl/defaults.sv
// Project-wide data-path defaults shared by the memory-side blocks.
package defaults;
  localparam int WORD_SIZE = 32;
endpackage

// File: rtl/sram_ctrl_pkg.sv
// Shared types and byte-lane constants for the SRAM controller.
package sram_ctrl_pkg;
  localparam int WORD_SIZE = defaults::WORD_SIZE;
  localparam int BYTE_W    = 8;
  localparam int NUM_LANES = WORD_SIZE / BYTE_W;

  typedef enum logic {
    IDLE = 1'b0,
    RMW  = 1'b1
  } state_e;
endpackage

// File: rtl/sram_ctrl_be_merge.sv
// Byte-lane merge: lanes with an enable take new data, the rest keep the old word.
module be_merge
  import sram_ctrl_pkg::*;
(
  input  logic [WORD_SIZE-1:0] i_new,
  input  logic [WORD_SIZE-1:0] i_old,
  input  logic [NUM_LANES-1:0] i_be,
  output logic [WORD_SIZE-1:0] o_merged
);

  always_comb begin
    o_merged = i_old;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (i_be[i]) o_merged[i*BYTE_W +: BYTE_W] = i_new[i*BYTE_W +: BYTE_W];
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// SRAM controller: port A serves instruction fetch, port B serves loads and the
// read half of partial-store read-modify-write; one shared write port.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int num_words    = 4096,
  parameter int l2_num_words = 12
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_if_req,
  input  logic [31:0]             i_if_addr,
  output logic                    o_if_ready,
  output logic                    o_if_valid,
  output logic                    o_if_err,
  output logic [WORD_SIZE-1:0]    o_if_data,
  input  logic                    i_ls_req,
  input  logic                    i_ls_we,
  input  logic [31:0]             i_ls_addr,
  input  logic [WORD_SIZE-1:0]    i_ls_wdata,
  input  logic [NUM_LANES-1:0]    i_ls_be,
  output logic                    o_ls_ready,
  output logic                    o_ls_valid,
  output logic                    o_ls_err,
  output logic [WORD_SIZE-1:0]    o_ls_rdata,
  output logic                    o_sram_re_A,
  output logic [l2_num_words-1:0] o_sram_addr_A,
  input  logic [WORD_SIZE-1:0]    i_sram_data_A,
  output logic                    o_sram_re_B,
  output logic [l2_num_words-1:0] o_sram_addr_B,
  input  logic [WORD_SIZE-1:0]    i_sram_data_B,
  output logic                    o_sram_we,
  output logic [l2_num_words-1:0] o_sram_waddr,
  output logic [WORD_SIZE-1:0]    o_sram_wdata
);

  localparam logic [32:0] ADDR_LIMIT = 33'(num_words) << 2;

  state_e                  state_q, state_d;
  logic                    if_valid_q, if_valid_d;
  logic                    if_err_q, if_err_d;
  logic                    ls_valid_q, ls_valid_d;
  logic                    ls_err_q, ls_err_d;
  logic                    ls_rd_q, ls_rd_d;
  logic [l2_num_words-1:0] rmw_addr_q, rmw_addr_d;
  logic [WORD_SIZE-1:0]    rmw_wdata_q, rmw_wdata_d;
  logic [NUM_LANES-1:0]    rmw_be_q, rmw_be_d;

  logic                    if_bad, ls_bad, if_acc, ls_acc;
  logic [l2_num_words-1:0] if_word, ls_word;
  logic [WORD_SIZE-1:0]    merged;

  assign if_word = i_if_addr[l2_num_words+1:2];
  assign ls_word = i_ls_addr[l2_num_words+1:2];
  assign if_bad  = (i_if_addr[1:0] != 2'b00) || ({1'b0, i_if_addr} >= ADDR_LIMIT);
  assign ls_bad  = (i_ls_addr[1:0] != 2'b00) || ({1'b0, i_ls_addr} >= ADDR_LIMIT);

  be_merge u_be_merge (
    .i_new    (rmw_wdata_q),
    .i_old    (i_sram_data_B),
    .i_be     (rmw_be_q),
    .o_merged (merged)
  );

  assign o_ls_ready = (state_q == IDLE);
  assign ls_acc     = i_ls_req && o_ls_ready && !i_rst;

  always_comb begin
    state_d       = state_q;
    rmw_addr_d    = rmw_addr_q;
    rmw_wdata_d   = rmw_wdata_q;
    rmw_be_d      = rmw_be_q;
    if_valid_d    = 1'b0;
    if_err_d      = 1'b0;
    ls_valid_d    = 1'b0;
    ls_err_d      = 1'b0;
    ls_rd_d       = 1'b0;
    o_sram_re_A   = 1'b0;
    o_sram_addr_A = if_word;
    o_sram_re_B   = 1'b0;
    o_sram_addr_B = ls_word;
    o_sram_we     = 1'b0;
    o_sram_waddr  = ls_word;
    o_sram_wdata  = i_ls_wdata;

    if (state_q == RMW) begin
      // Old word read last cycle is on port B now; write back the merge.
      o_sram_we    = 1'b1;
      o_sram_waddr = rmw_addr_q;
      o_sram_wdata = merged;
      ls_valid_d   = 1'b1;
      state_d      = IDLE;
    end else if (ls_acc) begin
      ls_valid_d = 1'b1;
      if (ls_bad) begin
        ls_err_d = 1'b1;
      end else if (!i_ls_we) begin
        o_sram_re_B = 1'b1;
        ls_rd_d     = 1'b1;
      end else if (i_ls_be == '1) begin
        o_sram_we = 1'b1;
      end else if (i_ls_be != '0) begin
        o_sram_re_B = 1'b1;
        rmw_addr_d  = ls_word;
        rmw_wdata_d = i_ls_wdata;
        rmw_be_d    = i_ls_be;
        ls_valid_d  = 1'b0;
        state_d     = RMW;
      end
    end

    // Stall a fetch that would race a write to the same word.
    o_if_ready = !(o_sram_we && (if_word == o_sram_waddr));
    if_acc     = i_if_req && o_if_ready && !i_rst;
    if (if_acc) begin
      if_valid_d = 1'b1;
      if (if_bad) if_err_d = 1'b1;
      else        o_sram_re_A = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      if_valid_q  <= 1'b0;
      if_err_q    <= 1'b0;
      ls_valid_q  <= 1'b0;
      ls_err_q    <= 1'b0;
      ls_rd_q     <= 1'b0;
      rmw_addr_q  <= '0;
      rmw_wdata_q <= '0;
      rmw_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      if_valid_q  <= if_valid_d;
      if_err_q    <= if_err_d;
      ls_valid_q  <= ls_valid_d;
      ls_err_q    <= ls_err_d;
      ls_rd_q     <= ls_rd_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_wdata_q <= rmw_wdata_d;
      rmw_be_q    <= rmw_be_d;
    end
  end

  assign o_if_valid = if_valid_q;
  assign o_if_err   = if_err_q;
  assign o_ls_valid = ls_valid_q;
  assign o_ls_err   = ls_err_q;
  assign o_if_data  = (if_valid_q && !if_err_q) ? i_sram_data_A : '0;
  assign o_ls_rdata = (ls_valid_q && ls_rd_q) ? i_sram_data_B : '0;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a synchronous-read SRAM model.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ready, if_valid, if_err;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_we, ls_ready, ls_valid, ls_err;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0]  ls_be;
  logic        re_a, re_b, we;
  logic [11:0] addr_a, addr_b, waddr;
  logic [31:0] data_a, data_b, wdata;

  logic [31:0] mem [0:4095];
  logic        pl_we, mem_clr;
  logic [11:0] pl_addr;
  logic [31:0] pl_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_ctrl #(.num_words(4096), .l2_num_words(12)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ready(if_ready),
    .o_if_valid(if_valid), .o_if_err(if_err), .o_if_data(if_data),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr),
    .i_ls_wdata(ls_wdata), .i_ls_be(ls_be), .o_ls_ready(ls_ready),
    .o_ls_valid(ls_valid), .o_ls_err(ls_err), .o_ls_rdata(ls_rdata),
    .o_sram_re_A(re_a), .o_sram_addr_A(addr_a), .i_sram_data_A(data_a),
    .o_sram_re_B(re_b), .o_sram_addr_B(addr_b), .i_sram_data_B(data_b),
    .o_sram_we(we), .o_sram_waddr(waddr), .o_sram_wdata(wdata)
  );

  // SRAM model: read returns the pre-write contents on a same-edge collision.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
    end else begin
      if (pl_we) mem[pl_addr] <= pl_data;
      if (we)    mem[waddr]   <= wdata;
    end
    if (re_a) data_a <= mem[addr_a];
    if (re_b) data_b <= mem[addr_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0;
    ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0; ls_be = 0;
    pl_we = 0;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk); idle_inputs(); pl_we = 1; pl_addr = a; pl_data = d;
    @(negedge clk); pl_we = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    data_a = 0; data_b = 0; pl_addr = 0; pl_data = 0;
    idle_inputs();
    rst = 1; mem_clr = 1;
    @(negedge clk); @(negedge clk);
    mem_clr = 0;
    if_req = 1; if_addr = 32'h10; ls_req = 1; ls_addr = 32'h20;
    #1;
    chk("rst_ls_ready", ls_ready, 1);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_ls_valid", ls_valid, 0);
    chk("rst_re_a", re_a, 0);
    chk("rst_re_b", re_b, 0);
    chk("rst_we", we, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    @(negedge clk); idle_inputs(); rst = 0;
    preload(12'd4, 32'hDEADBEEF);

    // Fetch of 0x10
    @(negedge clk); if_req = 1; if_addr = 32'h10; #1;
    chk("f_ready", if_ready, 1);
    chk("f_re_a", re_a, 1);
    chk("f_addr_a", 32'(addr_a), 4);
    @(negedge clk); idle_inputs(); #1;
    chk("f_valid", if_valid, 1);
    chk("f_data", if_data, 32'hDEADBEEF);
    chk("f_err", if_err, 0);
    @(negedge clk); #1;
    chk("f_valid_pulse", if_valid, 0);

    // Full-word store then load of 0x20
    @(negedge clk); ls_req = 1; ls_we = 1; ls_addr = 32'h20; ls_wdata = 32'h11223344; ls_be = 4'hF; #1;
    chk("st_we", we, 1);
    chk("st_waddr", 32'(waddr), 8);
    chk("st_wdata", wdata, 32'h11223344);
    chk("st_re_b", re_b, 0);
    @(negedge clk); idle_inputs(); #1;
    chk("st_valid", ls_valid, 1);
    chk("st_rdata", ls_rdata, 0);
    chk("st_ready", ls_ready, 1);
    chk("st_mem", mem[8], 32'h11223344);
    @(negedge clk); ls_req = 1; ls_addr = 32'h20; #1;
    chk("ld_re_b", re_b, 1);
    chk("ld_addr_b", 32'(addr_b), 8);
    @(negedge clk); idle_inputs(); #1;
    chk("ld_valid", ls_valid, 1);
    chk("ld_rdata", ls_rdata, 32'h11223344);
    chk("ld_err", ls_err, 0);

    // Back-to-back loads
    @(negedge clk); ls_req = 1; ls_addr = 32'h20;
    @(negedge clk); ls_addr = 32'h10; #1;
    chk("b2b_re_b", re_b, 1);
    chk("b2b_valid1", ls_valid, 1);
    chk("b2b_rdata1", ls_rdata, 32'h11223344);
    @(negedge clk); idle_inputs(); #1;
    chk("b2b_valid2", ls_valid, 1);
    chk("b2b_rdata2", ls_rdata, 32'hDEADBEEF);

    // Simultaneous fetch and load
    @(negedge clk); if_req = 1; if_addr = 32'h20; ls_req = 1; ls_addr = 32'h10; #1;
    chk("sim_re_a", re_a, 1);
    chk("sim_re_b", re_b, 1);
    @(negedge clk); idle_inputs(); #1;
    chk("sim_if_data", if_data, 32'h11223344);
    chk("sim_ls_rdata", ls_rdata, 32'hDEADBEEF);

    // Partial store with fetch colliding in the RMW write cycle
    preload(12'd8, 32'hAABBCCDD);
    @(negedge clk); ls_req = 1; ls_we = 1; ls_addr = 32'h20; ls_wdata = 32'h00000055; ls_be = 4'b0001; #1;
    chk("rmw_re_b", re_b, 1);
    chk("rmw_we_n", we, 0);
    chk("rmw_addr_b", 32'(addr_b), 8);
    @(negedge clk); idle_inputs(); if_req = 1; if_addr = 32'h20; #1;
    chk("rmw_ls_ready", ls_ready, 0);
    chk("rmw_we", we, 1);
    chk("rmw_waddr", 32'(waddr), 8);
    chk("rmw_wdata", wdata, 32'hAABBCC55);
    chk("rmw_if_ready", if_ready, 0);
    chk("rmw_re_a", re_a, 0);
    chk("rmw_ls_valid_n", ls_valid, 0);
    @(negedge clk); #1;
    chk("rmw_ls_valid", ls_valid, 1);
    chk("rmw_ls_rdata", ls_rdata, 0);
    chk("rmw_mem", mem[8], 32'hAABBCC55);
    chk("rmw_if_ready2", if_ready, 1);
    chk("rmw_re_a2", re_a, 1);
    chk("rmw_if_valid_n", if_valid, 0);
    @(negedge clk); idle_inputs(); #1;
    chk("rmw_if_valid", if_valid, 1);
    chk("rmw_if_data", if_data, 32'hAABBCC55);

    // Erroring requests
    @(negedge clk); ls_req = 1; ls_addr = 32'h22; #1;
    chk("err1_re_b", re_b, 0);
    @(negedge clk); ls_addr = 32'h4000; #1;
    chk("err2_re_b", re_b, 0);
    chk("err1_valid", ls_valid, 1);
    chk("err1_err", ls_err, 1);
    chk("err1_rdata", ls_rdata, 0);
    @(negedge clk); idle_inputs(); if_req = 1; if_addr = 32'h4000; #1;
    chk("err2_valid", ls_valid, 1);
    chk("err2_err", ls_err, 1);
    chk("err2_rdata", ls_rdata, 0);
    chk("ferr_re_a", re_a, 0);
    @(negedge clk); idle_inputs(); #1;
    chk("ferr_valid", if_valid, 1);
    chk("ferr_err", if_err, 1);
    chk("ferr_data", if_data, 0);

    // Store with no byte enables
    @(negedge clk); ls_req = 1; ls_we = 1; ls_addr = 32'h24; ls_wdata = 32'hFFFFFFFF; ls_be = 4'b0000; #1;
    chk("be0_we", we, 0);
    chk("be0_re_b", re_b, 0);
    @(negedge clk); idle_inputs(); #1;
    chk("be0_valid", ls_valid, 1);
    chk("be0_rdata", ls_rdata, 0);
    chk("be0_mem", mem[9], 0);

    // Reset pulsed while in RMW
    @(negedge clk); ls_req = 1; ls_we = 1; ls_addr = 32'h24; ls_wdata = 32'h0000AB00; ls_be = 4'b0010; #1;
    chk("rr_re_b", re_b, 1);
    @(negedge clk); idle_inputs(); rst = 1; #1;
    chk("rr_we", we, 0);
    chk("rr_ls_ready", ls_ready, 1);
    @(negedge clk); rst = 0; #1;
    chk("rr_valid", ls_valid, 0);
    chk("rr_ready", ls_ready, 1);
    chk("rr_mem", mem[9], 0);
    @(negedge clk); #1;
    chk("rr_valid2", ls_valid, 0);
    chk("rr_we2", we, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
